// File: rtl/ccm_requester.sv
// rtl/ccm_requester.sv - LSU-side initiator for the ccm_controller request port
// One transaction in flight; reads time out after TIMEOUT wait cycles with an error response.
module ccm_requester #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_resp_valid,
   input  logic                  i_resp_ready,
   output logic [DATA_WIDTH-1:0] o_resp_rdata,
   output logic                  o_resp_err,
   output logic                  o_cntlr_rd,
   output logic [ADDR_WIDTH-1:0] o_cntlr_raddr,
   input  logic [DATA_WIDTH-1:0] i_cntlr_rd_data,
   input  logic                  i_cntlr_rd_valid,
   output logic                  o_cntlr_wr,
   output logic [ADDR_WIDTH-1:0] o_cntlr_waddr,
   output logic [DATA_WIDTH-1:0] o_cntlr_wr_data,
   output logic                  o_stray_rd_valid,
   output logic [CNT_WIDTH-1:0]  o_rd_count,
   output logic [CNT_WIDTH-1:0]  o_wr_count
);

   localparam int             WCW     = $clog2(TIMEOUT);
   localparam logic [WCW-1:0] W_LAST  = WCW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RD_WAIT, S_RESP} state_t;

   state_t                r_state,       w_state;
   logic [WCW-1:0]        r_wcnt,        w_wcnt;
   logic                  r_cntlr_rd,    w_cntlr_rd;
   logic                  r_cntlr_wr,    w_cntlr_wr;
   logic [ADDR_WIDTH-1:0] r_raddr,       w_raddr;
   logic [ADDR_WIDTH-1:0] r_waddr,       w_waddr;
   logic [DATA_WIDTH-1:0] r_wr_data,     w_wr_data;
   logic                  r_resp_valid,  w_resp_valid;
   logic [DATA_WIDTH-1:0] r_resp_rdata,  w_resp_rdata;
   logic                  r_resp_err,    w_resp_err;
   logic [CNT_WIDTH-1:0]  r_rd_count,    w_rd_count;
   logic [CNT_WIDTH-1:0]  r_wr_count,    w_wr_count;

   always_comb begin
      w_state      = r_state;
      w_wcnt       = r_wcnt;
      w_cntlr_rd   = 1'b0;
      w_cntlr_wr   = 1'b0;
      w_raddr      = r_raddr;
      w_waddr      = r_waddr;
      w_wr_data    = r_wr_data;
      w_resp_valid = r_resp_valid;
      w_resp_rdata = r_resp_rdata;
      w_resp_err   = r_resp_err;
      w_rd_count   = r_rd_count;
      w_wr_count   = r_wr_count;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               if (i_req_we) begin
                  w_cntlr_wr = 1'b1;
                  w_waddr    = i_req_addr;
                  w_wr_data  = i_req_wdata;
                  w_state    = S_WRITE;
               end else begin
                  w_cntlr_rd = 1'b1;
                  w_raddr    = i_req_addr;
                  w_wcnt     = '0;
                  w_state    = S_RD_WAIT;
               end
            end
         end
         S_WRITE: begin
            w_wr_count = r_wr_count + CNT_WIDTH'(1);
            w_state    = S_IDLE;
         end
         S_RD_WAIT: begin
            // The first RD_WAIT cycle is the strobe cycle itself, so a zero-latency reply is caught.
            if (i_cntlr_rd_valid) begin
               w_resp_valid = 1'b1;
               w_resp_rdata = i_cntlr_rd_data;
               w_resp_err   = 1'b0;
               w_rd_count   = r_rd_count + CNT_WIDTH'(1);
               w_state      = S_RESP;
            end else if (r_wcnt == W_LAST) begin
               w_resp_valid = 1'b1;
               w_resp_rdata = '0;
               w_resp_err   = 1'b1;
               w_rd_count   = r_rd_count + CNT_WIDTH'(1);
               w_state      = S_RESP;
            end else begin
               w_wcnt = r_wcnt + WCW'(1);
            end
         end
         S_RESP: begin
            if (i_resp_ready) begin
               w_resp_valid = 1'b0;
               w_state      = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_wcnt       <= '0;
         r_cntlr_rd   <= 1'b0;
         r_cntlr_wr   <= 1'b0;
         r_raddr      <= '0;
         r_waddr      <= '0;
         r_wr_data    <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_rd_count   <= '0;
         r_wr_count   <= '0;
      end else begin
         r_state      <= w_state;
         r_wcnt       <= w_wcnt;
         r_cntlr_rd   <= w_cntlr_rd;
         r_cntlr_wr   <= w_cntlr_wr;
         r_raddr      <= w_raddr;
         r_waddr      <= w_waddr;
         r_wr_data    <= w_wr_data;
         r_resp_valid <= w_resp_valid;
         r_resp_rdata <= w_resp_rdata;
         r_resp_err   <= w_resp_err;
         r_rd_count   <= w_rd_count;
         r_wr_count   <= w_wr_count;
      end
   end

   assign o_req_ready      = (r_state == S_IDLE);
   assign o_resp_valid     = r_resp_valid;
   assign o_resp_rdata     = r_resp_rdata;
   assign o_resp_err       = r_resp_err;
   assign o_cntlr_rd       = r_cntlr_rd;
   assign o_cntlr_raddr    = r_raddr;
   assign o_cntlr_wr       = r_cntlr_wr;
   assign o_cntlr_waddr    = r_waddr;
   assign o_cntlr_wr_data  = r_wr_data;
   assign o_stray_rd_valid = i_cntlr_rd_valid && (r_state != S_RD_WAIT);
   assign o_rd_count       = r_rd_count;
   assign o_wr_count       = r_wr_count;

endmodule

// File: tb/tb_ccm_requester.sv
// tb/tb_ccm_requester.sv - directed bench for ccm_requester with a behavioural controller/SRAM stand-in
module tb_ccm_requester;

   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [10:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic        o_resp_valid;
   logic        i_resp_ready;
   logic [31:0] o_resp_rdata;
   logic        o_resp_err;
   logic        o_cntlr_rd;
   logic [10:0] o_cntlr_raddr;
   logic [31:0] i_cntlr_rd_data;
   logic        i_cntlr_rd_valid;
   logic        o_cntlr_wr;
   logic [10:0] o_cntlr_waddr;
   logic [31:0] o_cntlr_wr_data;
   logic        o_stray_rd_valid;
   logic [15:0] o_rd_count;
   logic [15:0] o_wr_count;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   ccm_requester #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT), .CNT_WIDTH(16)) u_dut (
      .i_clk            (clk),
      .i_rst            (i_rst),
      .i_req_valid      (i_req_valid),
      .o_req_ready      (o_req_ready),
      .i_req_we         (i_req_we),
      .i_req_addr       (i_req_addr),
      .i_req_wdata      (i_req_wdata),
      .o_resp_valid     (o_resp_valid),
      .i_resp_ready     (i_resp_ready),
      .o_resp_rdata     (o_resp_rdata),
      .o_resp_err       (o_resp_err),
      .o_cntlr_rd       (o_cntlr_rd),
      .o_cntlr_raddr    (o_cntlr_raddr),
      .i_cntlr_rd_data  (i_cntlr_rd_data),
      .i_cntlr_rd_valid (i_cntlr_rd_valid),
      .o_cntlr_wr       (o_cntlr_wr),
      .o_cntlr_waddr    (o_cntlr_waddr),
      .o_cntlr_wr_data  (o_cntlr_wr_data),
      .o_stray_rd_valid (o_stray_rd_valid),
      .o_rd_count       (o_rd_count),
      .o_wr_count       (o_wr_count)
   );

   // Controller stand-in: rd_lat cycles after the strobe cycle (negative = never answers).
   logic [31:0] mem [0:2047];
   int          rd_lat      = 1;
   int          inject_cnt  = 0;
   int          inject_done = 0;
   logic        pend        = 1'b0;
   int          pcnt        = 0;
   logic [10:0] paddr       = '0;
   logic        overlap     = 1'b0;

   always @(negedge clk) begin
      i_cntlr_rd_valid = 1'b0;
      if (o_cntlr_rd && o_cntlr_wr) overlap = 1'b1;
      if (o_cntlr_wr) mem[o_cntlr_waddr] = o_cntlr_wr_data;
      if (o_cntlr_rd && rd_lat >= 0) begin
         pend  = 1'b1;
         pcnt  = rd_lat;
         paddr = o_cntlr_raddr;
      end
      if (pend) begin
         if (pcnt == 0) begin
            i_cntlr_rd_valid = 1'b1;
            i_cntlr_rd_data  = mem[paddr];
            pend             = 1'b0;
         end else begin
            pcnt--;
         end
      end
      if (inject_cnt != inject_done) begin
         i_cntlr_rd_valid = 1'b1;
         i_cntlr_rd_data  = 32'hBAD0BAD0;
         inject_done      = inject_cnt;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge of the cycle after acceptance.
   task automatic issue(input logic we, input logic [10:0] addr, input logic [31:0] data);
      int k;
      i_req_valid = 1'b1;
      i_req_we    = we;
      i_req_addr  = addr;
      i_req_wdata = data;
      k = 0;
      while (!o_req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("req_accept_bound", 64'(k < 20), 1);
      @(negedge clk);
      i_req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      while (!o_resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_resp(input string tag);
      i_resp_ready = 1'b1;
      @(negedge clk);
      check({tag, "_resp_cleared"}, o_resp_valid, 0);
      check({tag, "_req_ready"}, o_req_ready, 1);
      i_resp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic seen;
      i_rst        = 1'b1;
      i_req_valid  = 1'b0;
      i_req_we     = 1'b0;
      i_req_addr   = '0;
      i_req_wdata  = '0;
      i_resp_ready = 1'b0;
      i_cntlr_rd_data = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", o_req_ready, 1);
      check("rst_resp_valid", o_resp_valid, 0);
      check("rst_cntlr_rd", o_cntlr_rd, 0);
      check("rst_cntlr_wr", o_cntlr_wr, 0);
      check("rst_rdata", o_resp_rdata, 0);
      check("rst_counts", {o_rd_count, o_wr_count}, 0);
      i_rst = 1'b0;
      @(negedge clk);

      // 1: posted write
      issue(1'b1, 11'h00A, 32'hDEADBEEF);
      check("t1_wr", o_cntlr_wr, 1);
      check("t1_rd", o_cntlr_rd, 0);
      check("t1_waddr", o_cntlr_waddr, 11'd10);
      check("t1_wdata", o_cntlr_wr_data, 32'hDEADBEEF);
      check("t1_busy", o_req_ready, 0);
      @(negedge clk);
      check("t1_wr_pulse", o_cntlr_wr, 0);
      check("t1_wr_count", o_wr_count, 1);
      check("t1_no_resp", o_resp_valid, 0);

      // 2: read back through the memory model
      rd_lat = 1;
      issue(1'b0, 11'h00A, 32'h0);
      check("t2_rd", o_cntlr_rd, 1);
      check("t2_raddr", o_cntlr_raddr, 11'd10);
      wait_resp(lat);
      check("t2_lat", 64'(lat), 2);
      check("t2_rdata", o_resp_rdata, 32'hDEADBEEF);
      check("t2_err", o_resp_err, 0);
      check("t2_rd_count", o_rd_count, 1);
      finish_resp("t2");

      // 3: timeout, then a late valid
      rd_lat = -1;
      issue(1'b0, 11'h003, 32'h0);
      check("t3_rd", o_cntlr_rd, 1);
      wait_resp(lat);
      check("t3_lat", 64'(lat), TIMEOUT);
      check("t3_err", o_resp_err, 1);
      check("t3_rdata", o_resp_rdata, 0);
      check("t3_rd_count", o_rd_count, 2);
      #1 inject_cnt++;
      @(negedge clk);
      #1;
      check("t3_stray", o_stray_rd_valid, 1);
      check("t3_hold_valid", o_resp_valid, 1);
      check("t3_hold_rdata", o_resp_rdata, 0);
      check("t3_count_after_stray", o_rd_count, 2);
      finish_resp("t3");
      #1 check("t3_stray_clear", o_stray_rd_valid, 0);

      // 4: back-pressured response, zero-latency reply
      rd_lat = 0;
      @(negedge clk);
      issue(1'b1, 11'h007, 32'h12345678);
      issue(1'b0, 11'h007, 32'h0);
      wait_resp(lat);
      check("t4_lat", 64'(lat), 1);
      i_req_valid = 1'b1;
      i_req_we    = 1'b1;
      i_req_addr  = 11'h009;
      i_req_wdata = 32'h99;
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", o_resp_valid, 1);
         check("t4_hold_rdata", o_resp_rdata, 32'h12345678);
         check("t4_busy", o_req_ready, 0);
         @(negedge clk);
      end
      check("t4_wr_count_held", o_wr_count, 2);
      finish_resp("t4");
      @(negedge clk);
      check("t4_new_wr", o_cntlr_wr, 1);
      check("t4_new_waddr", o_cntlr_waddr, 11'h009);
      i_req_valid = 1'b0;
      @(negedge clk);
      check("t4_wr_count", o_wr_count, 3);

      // 5: back-to-back write then read with req_valid held
      rd_lat      = 1;
      i_req_valid = 1'b1;
      i_req_we    = 1'b1;
      i_req_addr  = 11'h005;
      i_req_wdata = 32'h11;
      @(negedge clk);
      check("t5_wr", {o_cntlr_wr, o_cntlr_rd}, 2'b10);
      check("t5_wdata", o_cntlr_wr_data, 32'h11);
      i_req_we = 1'b0;
      @(negedge clk);
      check("t5_gap", {o_cntlr_wr, o_cntlr_rd}, 2'b00);
      check("t5_ready", o_req_ready, 1);
      @(negedge clk);
      check("t5_rd", {o_cntlr_wr, o_cntlr_rd}, 2'b01);
      check("t5_raddr", o_cntlr_raddr, 11'h005);
      i_req_valid = 1'b0;
      wait_resp(lat);
      check("t5_lat", 64'(lat), 2);
      check("t5_rdata", o_resp_rdata, 32'h11);
      check("t5_err", o_resp_err, 0);
      finish_resp("t5");
      check("t5_no_overlap", overlap, 0);
      check("t5_counts", {o_rd_count, o_wr_count}, {16'd4, 16'd4});

      // 6: reset during RD_WAIT
      rd_lat = -1;
      issue(1'b0, 11'h001, 32'h0);
      @(negedge clk);
      @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      check("t6_ready", o_req_ready, 1);
      check("t6_counts", {o_rd_count, o_wr_count}, 0);
      check("t6_resp", o_resp_valid, 0);
      check("t6_strobes", {o_cntlr_rd, o_cntlr_wr}, 0);
      i_rst = 1'b0;
      seen  = 1'b0;
      repeat (TIMEOUT + 4) begin
         @(negedge clk);
         if (o_resp_valid) seen = 1'b1;
      end
      check("t6_no_resp", seen, 0);
      check("t6_idle", o_req_ready, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
